// File: rtl/dsp_mac_pipe.sv
// -----------------------------------------------------------------------------
// dsp_mac_pipe
//   Pipelined signed multiply-accumulate with an optional pre-adder.
//   S1 registers a and pre = use_pre ? (pre_sub ? d-b : d+b) : b.
//   S2 registers prod = a*pre, sign-extended to ACC_W.
//   S3 accumulates ACC_LEN products per group; in_last may close a group early.
//   OUT holds the closed group sum until downstream takes it.
//   A sample accepted on edge N shows up at the output on edge N+3.
//   A stalled output freezes the whole pipeline.
//
// Configuration macro:
//   DSP_MAC_SAT_EN  defined   : an overflowing accumulation step clamps to the
//                               signed ACC_W max/min.
//                   undefined : accumulation wraps modulo 2^ACC_W.
//   out_ovf reports a signed overflow in the group in both builds.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready input handshake (in_ready = ~stall & ~rst)
//   a, b, d             signed operands (A_W, B_W, B_W bits)
//   use_pre, pre_sub    pre-adder select / subtract select
//   in_last             closes the current group with this sample
//   out_valid/out_ready output handshake
//   out_data, out_ovf   group sum (ACC_W bits signed) and group overflow flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dsp_mac_pipe #(
    parameter int unsigned A_W     = 18,
    parameter int unsigned B_W     = 18,
    parameter int unsigned ACC_W   = 48,
    parameter int unsigned ACC_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [B_W-1:0]   d,
    input  logic             use_pre,
    input  logic             pre_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int unsigned PRE_W  = B_W + 1;
    localparam int unsigned PROD_W = A_W + B_W + 1;
    localparam int unsigned CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

`ifdef DSP_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // ---------------------------------------------------------------------
    // Handshake / stall
    // ---------------------------------------------------------------------
    logic stall_c;
    logic accept_c;

    // ---------------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------------
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_last_q,  s1_last_d;
    logic signed [A_W-1:0]    s1_a_q,     s1_a_d;
    logic signed [PRE_W-1:0]  s1_pre_q,   s1_pre_d;

    logic                     s2_valid_q, s2_valid_d;
    logic                     s2_last_q,  s2_last_d;
    logic signed [ACC_W-1:0]  s2_prod_q,  s2_prod_d;

    logic signed [ACC_W-1:0]  acc_q,      acc_d;
    logic [CNT_W-1:0]         cnt_q,      cnt_d;
    logic                     ovf_q,      ovf_d;
    logic                     s3_close_q, s3_close_d;

    logic                     out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0]  out_data_q,  out_data_d;
    logic                     out_ovf_q,   out_ovf_d;

    // Stalled whenever a result is presented and not taken.
    assign stall_c  = out_valid_q & ~out_ready;
    assign in_ready = ~stall_c & ~rst;
    assign accept_c = in_valid & in_ready;

    // ---------------------------------------------------------------------
    // S1: operand capture and pre-adder
    // ---------------------------------------------------------------------
    logic signed [PRE_W-1:0] b_ext_c;
    logic signed [PRE_W-1:0] d_ext_c;

    always_comb begin
        b_ext_c    = $signed({b[B_W-1], b});
        d_ext_c    = $signed({d[B_W-1], d});
        s1_valid_d = accept_c;
        s1_last_d  = in_last;
        s1_a_d     = $signed(a);
        s1_pre_d   = b_ext_c;
        if (use_pre) begin
            if (pre_sub) begin
                s1_pre_d = d_ext_c - b_ext_c;
            end else begin
                s1_pre_d = d_ext_c + b_ext_c;
            end
        end
    end

    // ---------------------------------------------------------------------
    // S2: multiply at full product width, then sign-extend to ACC_W
    // ---------------------------------------------------------------------
    logic signed [PROD_W-1:0] a_ext_c;
    logic signed [PROD_W-1:0] pre_ext_c;
    logic signed [PROD_W-1:0] prod_c;

    always_comb begin
        a_ext_c    = PROD_W'(s1_a_q);
        pre_ext_c  = PROD_W'(s1_pre_q);
        prod_c     = a_ext_c * pre_ext_c;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_prod_d  = ACC_W'(prod_c);
    end

    // ---------------------------------------------------------------------
    // S3: accumulate. cnt==0 marks group start, so a stale acc is simply
    // overwritten by the first product of the next group.
    // ---------------------------------------------------------------------
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] step_val_c;
    logic                    step_ovf_c;
    logic                    close_c;

    always_comb begin
        sum_c      = acc_q + s2_prod_q;
        // Signed overflow: operands agree in sign, result does not.
        step_ovf_c = (acc_q[ACC_W-1] == s2_prod_q[ACC_W-1]) &&
                     (sum_c[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef DSP_MAC_SAT_EN
        // The true sum has the sign of the (equal-signed) operands.
        if (step_ovf_c) begin
            step_val_c = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            step_val_c = sum_c;
        end
`else
        step_val_c = sum_c;
`endif
        close_c    = s2_valid_q & (s2_last_q | (cnt_q == CNT_LAST));

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        s3_close_d = 1'b0;
        if (s2_valid_q) begin
            if (cnt_q == '0) begin
                acc_d = s2_prod_q;
                ovf_d = 1'b0;
            end else begin
                acc_d = step_val_c;
                ovf_d = ovf_q | step_ovf_c;
            end
            if (close_c) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            s3_close_d = close_c;
        end
    end

    // ---------------------------------------------------------------------
    // OUT: load on close (back-to-back without a bubble), clear on take
    // ---------------------------------------------------------------------
    always_comb begin
        out_valid_d = s3_close_q | (out_valid_q & ~out_ready);
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (s3_close_q) begin
            out_data_d = acc_q;
            out_ovf_d  = ovf_q;
        end
    end

    // ---------------------------------------------------------------------
    // State registers: everything holds while stalled
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_pre_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_prod_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            s3_close_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (!stall_c) begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_a_q      <= s1_a_d;
            s1_pre_q    <= s1_pre_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_prod_q   <= s2_prod_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            s3_close_q  <= s3_close_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
`timescale 1ns/1ps

module tb_dsp_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-parameter instance
    logic        in_valid, in_ready, use_pre, pre_sub, in_last;
    logic        out_valid, out_ready, out_ovf;
    logic [17:0] a, b, d;
    logic [47:0] out_data;

    // Narrow instance for the overflow case
    logic        o_in_valid, o_in_ready, o_use_pre, o_pre_sub, o_in_last;
    logic        o_out_valid, o_out_ready, o_out_ovf;
    logic [7:0]  o_a, o_b, o_d;
    logic [16:0] o_out_data;

    dsp_mac_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .d(d),
        .use_pre(use_pre), .pre_sub(pre_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    dsp_mac_pipe #(.A_W(8), .B_W(8), .ACC_W(17), .ACC_LEN(4)) dut_ovf (
        .clk(clk), .rst(rst),
        .in_valid(o_in_valid), .in_ready(o_in_ready),
        .a(o_a), .b(o_b), .d(o_d),
        .use_pre(o_use_pre), .pre_sub(o_pre_sub), .in_last(o_in_last),
        .out_valid(o_out_valid), .out_ready(o_out_ready),
        .out_data(o_out_data), .out_ovf(o_out_ovf)
    );

    int          total;
    int          bad;
    logic [48:0] q0[$];
    logic [17:0] q1[$];
    logic [48:0] e0;
    logic [17:0] e1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, need %0h", nm, got, exp);
        end
    endtask

    task automatic push0(input longint v, input logic ovf);
        q0.push_back({ovf, 48'(v)});
    endtask

    task automatic push1(input logic [16:0] v, input logic ovf);
        q1.push_back({ovf, v});
    endtask

    // Present one sample and hold it until accepted (bounded).
    task automatic send(input logic signed [17:0] av, input logic signed [17:0] bv,
                        input logic signed [17:0] dv, input logic up, input logic ps,
                        input logic last);
        logic ok;
        int   n;
        a = av; b = bv; d = dv; use_pre = up; pre_sub = ps; in_last = last;
        in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
    endtask

    task automatic send8(input logic signed [7:0] av, input logic signed [7:0] bv,
                         input logic last);
        logic ok;
        int   n;
        o_a = av; o_b = bv; o_d = '0; o_use_pre = 1'b0; o_pre_sub = 1'b0;
        o_in_last = last; o_in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = o_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        o_in_valid = 1'b0;
        o_in_last  = 1'b0;
        if (!ok) chk("accept8_timeout", 64'(ok), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        total = 0; bad = 0;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; d = '0; use_pre = 1'b0; pre_sub = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        o_in_valid = 1'b0; o_a = '0; o_b = '0; o_d = '0; o_use_pre = 1'b0; o_pre_sub = 1'b0;
        o_in_last = 1'b0; o_out_ready = 1'b1;

        // Scoreboard monitor: a transfer happens on the next edge when valid&ready here.
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (q0.size() == 0) begin
                        total++; bad++;
                        $display("FAIL dut_unexpected: got data %0h, need no result", out_data);
                    end else begin
                        e0 = q0.pop_front();
                        chk("dut_data", 64'(out_data), 64'(e0[47:0]));
                        chk("dut_ovf", 64'(out_ovf), 64'(e0[48]));
                    end
                end
                if (!rst && o_out_valid && o_out_ready) begin
                    if (q1.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ovf_unexpected: got data %0h, need no result", o_out_data);
                    end else begin
                        e1 = q1.pop_front();
                        chk("ovf_data", 64'(o_out_data), 64'(e1[16:0]));
                        chk("ovf_flag", 64'(o_out_ovf), 64'(e1[17]));
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_ovf_valid", 64'(o_out_valid), 64'(0));
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'(1));

        // Basic accumulate: 4 x (2*3) = 24, result on 3rd edge after last accept
        push0(24, 1'b0);
        repeat (4) send(2, 3, 0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency_edge%0d", k), 64'(out_valid), 64'(k == 3));
        end

        // Pre-subtract: -3 * (10-4) = -18
        push0(-18, 1'b0);
        send(-3, 4, 10, 1'b1, 1'b1, 1'b1);
        // Pre-add: 5 * (-7+2) = -25
        push0(-25, 1'b0);
        send(5, 2, -7, 1'b1, 1'b0, 1'b1);

        // Early close then a full group: 12, then 4
        push0(12, 1'b0);
        send(1, 5, 0, 1'b0, 1'b0, 1'b0);
        send(1, 7, 0, 1'b0, 1'b0, 1'b1);
        push0(4, 1'b0);
        repeat (4) send(1, 1, 0, 1'b0, 1'b0, 1'b0);

        // Negative products: 2 x (-1000*300) = -600000
        push0(-600000, 1'b0);
        send(-1000, 300, 0, 1'b0, 1'b0, 1'b0);
        send(-1000, 300, 0, 1'b0, 1'b0, 1'b1);

        // in_last on the 4th sample closes exactly one group: 10, then 4
        push0(10, 1'b0);
        send(1, 1, 0, 1'b0, 1'b0, 1'b0);
        send(1, 2, 0, 1'b0, 1'b0, 1'b0);
        send(1, 3, 0, 1'b0, 1'b0, 1'b0);
        send(1, 4, 0, 1'b0, 1'b0, 1'b1);
        push0(4, 1'b0);
        send(2, 2, 0, 1'b0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: results 8 and 9 pend, held for 5 cycles
        out_ready = 1'b0;
        push0(8, 1'b0);
        repeat (4) send(1, 2, 0, 1'b0, 1'b0, 1'b0);
        push0(9, 1'b0);
        send(3, 3, 0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_hold_data", 64'(out_data), 64'(8));
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_no_bubble_valid", 64'(out_valid), 64'(1));
        chk("bp_no_bubble_data", 64'(out_data), 64'(9));
        push0(4, 1'b0);
        send(2, 2, 0, 1'b0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        // Reset mid-group discards in-flight samples
        send(5, 5, 0, 1'b0, 1'b0, 1'b0);
        send(5, 5, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push0(4, 1'b0);
        repeat (4) send(1, 1, 0, 1'b0, 1'b0, 1'b0);

        // Overflow on the narrow instance: 4 x 16384 = 65536 does not fit 17 bits signed
`ifdef DSP_MAC_SAT_EN
        push1(17'h0FFFF, 1'b1);
`else
        push1(17'h10000, 1'b1);
`endif
        repeat (4) send8(-128, -128, 1'b0);
        // Next group starts with the flag cleared: 4 x 100 = 400
        push1(17'd400, 1'b0);
        repeat (4) send8(10, 10, 1'b0);

        // Drain
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_q0", 64'(q0.size()), 64'(0));
        chk("drain_q1", 64'(q1.size()), 64'(0));
        repeat (10) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
